// File: rtl/perf_counter_mmio.sv
// MMIO cycle / retired-instruction counters with snapshot, freeze and clear.
// Optional PERF_CNT_64_EN widens counters to 2*DATA_W with atomic high-half shadows.
module perf_counter_mmio #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              instr_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

`ifdef PERF_CNT_64_EN
    localparam int                CNT_W     = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(32);
`else
    localparam int                CNT_W     = DATA_W;
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(24);
`endif

    localparam logic [2:0] W_CYCLE      = 3'd0;
    localparam logic [2:0] W_INSTR      = 3'd1;
    localparam logic [2:0] W_CTRL       = 3'd2;
    localparam logic [2:0] W_SNAP       = 3'd3;
    localparam logic [2:0] W_SNAP_CYCLE = 3'd4;
    localparam logic [2:0] W_SNAP_INSTR = 3'd5;
`ifdef PERF_CNT_64_EN
    localparam logic [2:0] W_CYCLE_H    = 3'd6;
    localparam logic [2:0] W_INSTR_H    = 3'd7;
`endif

    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  snap_cycle_q, snap_cycle_d;
    logic [CNT_W-1:0]  snap_instr_q, snap_instr_d;
    logic              freeze_q, freeze_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
`ifdef PERF_CNT_64_EN
    logic [DATA_W-1:0] shadow_cycle_q, shadow_cycle_d;
    logic [DATA_W-1:0] shadow_instr_q, shadow_instr_d;
`endif

    logic [ADDR_W-1:0] offset;
    logic [2:0]        word;
    logic              hit;
    logic              rd_req;
    logic              wr_ctrl;
    logic              wr_snap;
    logic              clr;
    logic [DATA_W-1:0] rd_val;
    logic              wdata_unused;

    // Decode relative to the base so the window may sit at any alignment.
    assign offset       = mem_addr - BASE_ADDR;
    assign word         = offset[4:2];
    assign hit          = offset < WIN_BYTES;
    assign rd_req       = mem_ren && hit;
    assign wr_ctrl      = mem_wen && hit && (word == W_CTRL);
    assign wr_snap      = mem_wen && hit && (word == W_SNAP);
    assign clr          = wr_ctrl && mem_wdata[0];
    assign wdata_unused = ^mem_wdata[DATA_W-1:2];

    always_comb begin
        rd_val = '0;
        case (word)
            W_CYCLE:      rd_val = cycle_q[DATA_W-1:0];
            W_INSTR:      rd_val = instr_q[DATA_W-1:0];
            W_CTRL:       rd_val = {{(DATA_W-2){1'b0}}, freeze_q, 1'b0};
            W_SNAP_CYCLE: rd_val = snap_cycle_q[DATA_W-1:0];
            W_SNAP_INSTR: rd_val = snap_instr_q[DATA_W-1:0];
`ifdef PERF_CNT_64_EN
            W_CYCLE_H:    rd_val = shadow_cycle_q;
            W_INSTR_H:    rd_val = shadow_instr_q;
`endif
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        snap_cycle_d = snap_cycle_q;
        snap_instr_d = snap_instr_q;
        freeze_d     = freeze_q;
        rvalid_d     = rd_req;
        rdata_d      = rd_req ? rd_val : '0;

        // Clear beats the increment; a new FREEZE value only gates later cycles.
        if (clr) begin
            cycle_d = '0;
            instr_d = '0;
        end else if (!freeze_q) begin
            cycle_d = cycle_q + CNT_W'(1);
            instr_d = instr_q + CNT_W'(instr_valid);
        end
        if (wr_ctrl) begin
            freeze_d = mem_wdata[1];
        end
        if (wr_snap) begin
            snap_cycle_d = cycle_q;
            snap_instr_d = instr_q;
        end
    end

`ifdef PERF_CNT_64_EN
    // Low-half loads latch the high half so a low/high read pair is coherent.
    always_comb begin
        shadow_cycle_d = shadow_cycle_q;
        shadow_instr_d = shadow_instr_q;
        if (clr) begin
            shadow_cycle_d = '0;
            shadow_instr_d = '0;
        end else if (rd_req && word == W_CYCLE) begin
            shadow_cycle_d = cycle_q[CNT_W-1:DATA_W];
        end else if (rd_req && word == W_INSTR) begin
            shadow_instr_d = instr_q[CNT_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_cycle_q <= '0;
            shadow_instr_q <= '0;
        end else begin
            shadow_cycle_q <= shadow_cycle_d;
            shadow_instr_q <= shadow_instr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q      <= '0;
            instr_q      <= '0;
            snap_cycle_q <= '0;
            snap_instr_q <= '0;
            freeze_q     <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            snap_cycle_q <= snap_cycle_d;
            snap_instr_q <= snap_instr_d;
            freeze_q     <= freeze_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Directed bench for perf_counter_mmio: per-cycle model comparison plus literal checks;
// a narrow 8-bit instance exercises counter wrap-around in a few hundred cycles.
module tb_perf_counter_mmio;
    localparam logic [31:0] BASE         = 32'h8000_0010;
    localparam logic [31:0] A_CYCLE      = BASE + 32'h00;
    localparam logic [31:0] A_INSTR      = BASE + 32'h04;
    localparam logic [31:0] A_CTRL       = BASE + 32'h08;
    localparam logic [31:0] A_SNAP       = BASE + 32'h0C;
    localparam logic [31:0] A_SNAP_CYCLE = BASE + 32'h10;
    localparam logic [31:0] A_SNAP_INSTR = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic        instr_valid;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  rdata8;
    logic        rvalid8;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    perf_counter_mmio #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .instr_valid(instr_valid), .rdata(rdata), .rvalid(rvalid)
    );

    perf_counter_mmio #(.DATA_W(8), .ADDR_W(32), .BASE_ADDR(BASE)) dut8 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata[7:0]), .instr_valid(instr_valid), .rdata(rdata8), .rvalid(rvalid8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Reference model: register file as plain numbers, updated once per clock.
    logic [31:0] m_cyc, m_ins, m_snc, m_sni;
    logic        m_frz;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;

    function automatic logic [31:0] model_read(input logic [31:0] addr, output logic found);
        logic [31:0] off;
        off   = addr - BASE;
        found = 1'b1;
        if (off >= 32'd24) begin
            found = 1'b0;
            return 32'd0;
        end
        case (off / 4)
            0:       return m_cyc;
            1:       return m_ins;
            2:       return {30'd0, m_frz, 1'b0};
            4:       return m_snc;
            5:       return m_sni;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic        found;
        logic        clear;
        logic        new_frz;
        logic [31:0] v;
        logic [31:0] off;
        if (rst) begin
            m_cyc = 0; m_ins = 0; m_snc = 0; m_sni = 0; m_frz = 0;
            exp_rvalid = 0; exp_rdata = 0;
        end else begin
            exp_rvalid = 0;
            exp_rdata  = 0;
            if (mem_ren) begin
                v = model_read(mem_addr, found);
                if (found) begin
                    exp_rvalid = 1;
                    exp_rdata  = v;
                end
            end
            clear   = 0;
            new_frz = m_frz;
            off     = mem_addr - BASE;
            if (mem_wen && off < 32'd24) begin
                if (off / 4 == 2) begin
                    clear   = mem_wdata[0];
                    new_frz = mem_wdata[1];
                end
                if (off / 4 == 3) begin
                    m_snc = m_cyc;
                    m_sni = m_ins;
                end
            end
            if (clear) begin
                m_cyc = 0;
                m_ins = 0;
            end else if (!m_frz) begin
                m_cyc = m_cyc + 1;
                m_ins = m_ins + (instr_valid ? 32'd1 : 32'd0);
            end
            m_frz = new_frz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model rvalid", {31'd0, rvalid}, {31'd0, exp_rvalid});
            check("model rdata", rdata, exp_rdata);
        end
    end

    task automatic step(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic iv);
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_wdata = wd; instr_valid = iv;
        @(posedge clk);
        #1;
        mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_wdata = 0; instr_valid = 0;
    endtask

    task automatic idle(input int n, input logic iv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, iv);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] wd, input logic iv);
        step(1'b0, 1'b1, addr, wd, iv);
        $display("st %08h <- %08h", addr, wd);
    endtask

    task automatic ld(input string name, input logic [31:0] addr,
                      input logic [31:0] exp_v, input logic exp_rv);
        step(1'b1, 1'b0, addr, 32'd0, 1'b0);
        $display("ld %08h -> rvalid=%0b rdata=%08h", addr, rvalid, rdata);
        check({name, " rvalid"}, {31'd0, rvalid}, {31'd0, exp_rv});
        check({name, " rdata"}, rdata, exp_v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_addr = 0; mem_ren = 0; mem_wen = 0; mem_wdata = 0; instr_valid = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("reset rvalid", {31'd0, rvalid}, 32'd0);
        check("reset rdata", rdata, 32'd0);

        // Free-running count after reset
        idle(10, 1'b1);
        ld("CYCLE after 10", A_CYCLE, 32'd10, 1'b1);
        ld("INSTR after 10", A_INSTR, 32'd10, 1'b1);

        // Retire pattern 1,0,1,1,0 after a clear
        st(A_CTRL, 32'h1, 1'b0);
        step(0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1'b0);
        step(0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1'b0);
        ld("INSTR pattern", A_INSTR, 32'd3, 1'b1);

        // CLR wins over a simultaneous increment
        st(A_CTRL, 32'h1, 1'b1);
        idle(1, 1'b1);
        ld("CYCLE after clr", A_CYCLE, 32'd1, 1'b1);
        ld("INSTR after clr", A_INSTR, 32'd1, 1'b1);

        // Freeze holds both counters; back-to-back loads
        st(A_CTRL, 32'h2, 1'b1);
        idle(20, 1'b1);
        ld("CYCLE frozen a", A_CYCLE, 32'd4, 1'b1);
        ld("CYCLE frozen b", A_CYCLE, 32'd4, 1'b1);
        ld("INSTR frozen", A_INSTR, 32'd2, 1'b1);
        ld("CTRL readback", A_CTRL, 32'd2, 1'b1);
        st(A_CTRL, 32'h0, 1'b1);
        idle(3, 1'b1);
        ld("CYCLE resumed", A_CYCLE, 32'd7, 1'b1);
        ld("INSTR resumed", A_INSTR, 32'd5, 1'b1);

        // Snapshot at cycle 0x50
        st(A_CTRL, 32'h1, 1'b0);
        idle(80, 1'b1);
        st(A_SNAP, 32'h0, 1'b0);
        idle(30, 1'b0);
        ld("CYCLE after snap", A_CYCLE, 32'h6F, 1'b1);
        ld("SNAP_CYCLE byte off", A_SNAP_CYCLE + 32'd3, 32'h50, 1'b1);
        ld("SNAP_INSTR", A_SNAP_INSTR, 32'h50, 1'b1);
        ld("SNAP reads 0", A_SNAP, 32'd0, 1'b1);
        st(A_CYCLE, 32'hDEAD, 1'b0);
        st(A_SNAP_CYCLE, 32'hBEEF, 1'b0);
        ld("CYCLE RO store", A_CYCLE, 32'h75, 1'b1);
        ld("SNAP_CYCLE RO store", A_SNAP_CYCLE, 32'h50, 1'b1);

        // Outside the window
        ld("unmapped +0x20", BASE + 32'h20, 32'd0, 1'b0);
        ld("unmapped +0x18", BASE + 32'h18, 32'd0, 1'b0);
        ld("unmapped below", BASE - 32'h4, 32'd0, 1'b0);

        // Wrap-around on the 8-bit instance: 0xFE, 0xFF, 0x00
        st(A_CTRL, 32'h1, 1'b0);
        idle(254, 1'b0);
        step(1'b1, 1'b0, A_CYCLE, 32'd0, 1'b0);
        $display("ld8 %08h -> rvalid=%0b rdata=%02h", A_CYCLE, rvalid8, rdata8);
        check("wrap8 0xFE", {24'd0, rdata8}, 32'hFE);
        step(1'b1, 1'b0, A_CYCLE, 32'd0, 1'b0);
        $display("ld8 %08h -> rvalid=%0b rdata=%02h", A_CYCLE, rvalid8, rdata8);
        check("wrap8 0xFF", {24'd0, rdata8}, 32'hFF);
        step(1'b1, 1'b0, A_CYCLE, 32'd0, 1'b0);
        $display("ld8 %08h -> rvalid=%0b rdata=%02h", A_CYCLE, rvalid8, rdata8);
        check("wrap8 0x00", {24'd0, rdata8}, 32'h00);
        check("wrap8 rvalid", {31'd0, rvalid8}, 32'd1);

        // Reset during a read suppresses the response
        rst = 1;
        step(1'b1, 1'b0, A_CYCLE, 32'd0, 1'b0);
        $display("ld %08h under reset -> rvalid=%0b rdata=%08h", A_CYCLE, rvalid, rdata);
        check("reset kills rvalid", {31'd0, rvalid}, 32'd0);
        check("reset kills rvalid8", {31'd0, rvalid8}, 32'd0);
        rst = 0;
        ld("CYCLE post reset", A_CYCLE, 32'd0, 1'b1);
        idle(2, 1'b0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
